// File: rtl/alu_unit.sv
// Single-cycle integer ALU with one execute register and a 2-entry result FIFO
// that presents completed results to the common data bus in issue order.
module alu_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              alu_mission,
  input  logic [5:0]        alu_op_type,
  input  logic [DATA_W-1:0] alu_rs1,
  input  logic [DATA_W-1:0] alu_rs2,
  input  logic [TAG_W-1:0]  alu_rob_dest,
  output logic              alu_busy,
  output logic              cdb_flag,
  output logic [TAG_W-1:0]  cdb_rename,
  output logic [DATA_W-1:0] cdb_value,
  input  logic              cdb_grant
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [5:0] OP_JALR  = 6'd4;
  localparam logic [5:0] OP_BEQ   = 6'd5;
  localparam logic [5:0] OP_BNE   = 6'd6;
  localparam logic [5:0] OP_BLT   = 6'd7;
  localparam logic [5:0] OP_BGE   = 6'd8;
  localparam logic [5:0] OP_BLTU  = 6'd9;
  localparam logic [5:0] OP_BGEU  = 6'd10;
  localparam logic [5:0] OP_ADDI  = 6'd19;
  localparam logic [5:0] OP_SLTI  = 6'd20;
  localparam logic [5:0] OP_SLTIU = 6'd21;
  localparam logic [5:0] OP_XORI  = 6'd22;
  localparam logic [5:0] OP_ORI   = 6'd23;
  localparam logic [5:0] OP_ANDI  = 6'd24;
  localparam logic [5:0] OP_SLLI  = 6'd25;
  localparam logic [5:0] OP_SRLI  = 6'd26;
  localparam logic [5:0] OP_SRAI  = 6'd27;
  localparam logic [5:0] OP_ADD   = 6'd28;
  localparam logic [5:0] OP_SUB   = 6'd29;
  localparam logic [5:0] OP_SLL   = 6'd30;
  localparam logic [5:0] OP_SLT   = 6'd31;
  localparam logic [5:0] OP_SLTU  = 6'd32;
  localparam logic [5:0] OP_XOR   = 6'd33;
  localparam logic [5:0] OP_SRL   = 6'd34;
  localparam logic [5:0] OP_SRA   = 6'd35;
  localparam logic [5:0] OP_OR    = 6'd36;
  localparam logic [5:0] OP_AND   = 6'd37;

  function automatic logic [DATA_W-1:0] b2v(input logic b);
    return {{(DATA_W-1){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] exec_op(input logic [5:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [SH_W-1:0]          sh;
    sa = a;
    sb = b;
    sh = b[SH_W-1:0];
    case (op)
      OP_JALR:           exec_op = (a + b) & ~b2v(1'b1);
      OP_BEQ:            exec_op = b2v(a == b);
      OP_BNE:            exec_op = b2v(a != b);
      OP_BLT:            exec_op = b2v(sa < sb);
      OP_BGE:            exec_op = b2v(sa >= sb);
      OP_BLTU:           exec_op = b2v(a < b);
      OP_BGEU:           exec_op = b2v(a >= b);
      OP_ADD, OP_ADDI:   exec_op = a + b;
      OP_SUB:            exec_op = a - b;
      OP_SLT, OP_SLTI:   exec_op = b2v(sa < sb);
      OP_SLTU, OP_SLTIU: exec_op = b2v(a < b);
      OP_XOR, OP_XORI:   exec_op = a ^ b;
      OP_OR, OP_ORI:     exec_op = a | b;
      OP_AND, OP_ANDI:   exec_op = a & b;
      OP_SLL, OP_SLLI:   exec_op = a << sh;
      OP_SRL, OP_SRLI:   exec_op = a >> sh;
      OP_SRA, OP_SRAI:   exec_op = sa >>> sh;
      default:           exec_op = '0;
    endcase
  endfunction

  logic              r_vld_p1;
  logic [TAG_W-1:0]  r_tag_p1;
  logic [DATA_W-1:0] r_val_p1;
  logic [TAG_W-1:0]  r_fifo_tag [2];
  logic [DATA_W-1:0] r_fifo_val [2];
  logic              r_head;
  logic [1:0]        r_count;

  logic              w_live;
  logic              w_pop;
  logic              w_push;
  logic              w_accept;
  logic              w_tail;
  logic [DATA_W-1:0] w_result_p0;

  assign w_result_p0 = exec_op(alu_op_type, alu_rs1, alu_rs2);

  // Busy looks one edge ahead: a new op could not leave execute next cycle.
  assign alu_busy = (r_count == 2'd2) || ((r_count == 2'd1) && r_vld_p1);
  assign w_live   = rdy && !flush;
  assign w_pop    = w_live && cdb_grant && (r_count != 2'd0);
  assign w_push   = w_live && r_vld_p1 && ((r_count != 2'd2) || w_pop);
  assign w_accept = w_live && alu_mission && !alu_busy;
  assign w_tail   = r_head ^ r_count[0];

  // p0 -> p1: execute register and FIFO control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_head   <= 1'b0;
      r_count  <= 2'd0;
    end else if (rdy) begin
      if (flush) begin
        r_vld_p1 <= 1'b0;
        r_head   <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        r_vld_p1 <= w_accept || (r_vld_p1 && !w_push);
        if (w_pop) r_head <= ~r_head;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_p1 <= alu_rob_dest;
      r_val_p1 <= w_result_p0;
    end
    if (w_push) begin
      r_fifo_tag[w_tail] <= r_tag_p1;
      r_fifo_val[w_tail] <= r_val_p1;
    end
  end

  // p1 -> p2: FIFO head presented on the CDB, zeroed while empty
  assign cdb_flag   = (r_count != 2'd0);
  assign cdb_rename = cdb_flag ? r_fifo_tag[r_head] : '0;
  assign cdb_value  = cdb_flag ? r_fifo_val[r_head] : '0;

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: opcode vector table plus ordering, backpressure,
// flush, reset and enable sequences.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        alu_mission;
  logic [5:0]  alu_op_type;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [3:0]  alu_rob_dest;
  logic        alu_busy;
  logic        cdb_flag;
  logic [3:0]  cdb_rename;
  logic [31:0] cdb_value;
  logic        cdb_grant;

  alu_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alu_mission(alu_mission), .alu_op_type(alu_op_type),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rob_dest(alu_rob_dest),
    .alu_busy(alu_busy), .cdb_flag(cdb_flag), .cdb_rename(cdb_rename),
    .cdb_value(cdb_value), .cdb_grant(cdb_grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] val;
  } bc_t;

  vec_t vecs [0:39];
  int   nv = 0;
  bc_t  bq [$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Every accepted broadcast, in the order the arbiter took it
  always @(posedge clk) begin
    if (!rst && rdy && !flush && cdb_flag && cdb_grant)
      bq.push_back({cdb_rename, cdb_value});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] tag, input logic [31:0] exp);
    vecs[nv] = {op, a, b, tag, exp};
    nv++;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    alu_mission  = 1'b1;
    alu_op_type  = op;
    alu_rs1      = a;
    alu_rs2      = b;
    alu_rob_dest = tag;
  endtask

  // Called at a negedge; waits for busy to clear, holds the mission for one edge
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    int w = 0;
    while (alu_busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_busy_timeout: busy %b required 0", alu_busy);
    end
    drive(op, a, b, tag);
    @(negedge clk);
    alu_mission = 1'b0;
  endtask

  task automatic wait_q(input int base, input int n);
    int w = 0;
    while (bq.size() < base + n && w < 40) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic chk_q(input string nm, input int base, input int idx,
                       input logic [3:0] tag, input logic [31:0] val);
    if (bq.size() > base + idx) begin
      chk({nm, "_tag"}, 32'(bq[base+idx].tag), 32'(tag));
      chk({nm, "_val"}, bq[base+idx].val, val);
    end else begin
      chk({nm, "_missing"}, 32'(bq.size() - base), 32'(idx + 1));
    end
  endtask

  initial begin
    int base;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; alu_mission = 1'b0; cdb_grant = 1'b0;
    alu_op_type = '0; alu_rs1 = '0; alu_rs2 = '0; alu_rob_dest = '0;

    add(6'd28, 32'd5,        32'd7,        4'd3,  32'd12);
    add(6'd29, 32'd5,        32'd7,        4'd1,  32'hFFFFFFFE);
    add(6'd19, 32'hFFFFFFFF, 32'd1,        4'd2,  32'h0);
    add(6'd37, 32'hF0F0,     32'hFF00,     4'd4,  32'hF000);
    add(6'd36, 32'hF0F0,     32'hFF00,     4'd5,  32'hFFF0);
    add(6'd33, 32'hF0F0,     32'hFF00,     4'd6,  32'h0FF0);
    add(6'd30, 32'd1,        32'h21,       4'd7,  32'd2);
    add(6'd34, 32'h80000000, 32'd4,        4'd8,  32'h08000000);
    add(6'd35, 32'h80000000, 32'h21,       4'd9,  32'hC0000000);
    add(6'd27, 32'h80000000, 32'd31,       4'd10, 32'hFFFFFFFF);
    add(6'd31, 32'hFFFFFFFF, 32'd1,        4'd11, 32'd1);
    add(6'd32, 32'd1,        32'hFFFFFFFF, 4'd12, 32'd1);
    add(6'd21, 32'hFFFFFFFF, 32'd1,        4'd13, 32'd0);
    add(6'd20, 32'h80000000, 32'd0,        4'd14, 32'd1);
    add(6'd5,  32'd5,        32'd5,        4'd15, 32'd1);
    add(6'd6,  32'd5,        32'd5,        4'd0,  32'd0);
    add(6'd7,  32'hFFFFFFFF, 32'd0,        4'd1,  32'd1);
    add(6'd8,  32'hFFFFFFFF, 32'd0,        4'd2,  32'd0);
    add(6'd9,  32'hFFFFFFFF, 32'd0,        4'd3,  32'd0);
    add(6'd10, 32'hFFFFFFFF, 32'd0,        4'd4,  32'd1);
    add(6'd4,  32'h1001,     32'h2,        4'd5,  32'h1002);
    add(6'd63, 32'h1234,     32'h5678,     4'd9,  32'd0);
    add(6'd0,  32'hFFFF,     32'hFFFF,     4'd6,  32'd0);
    add(6'd22, 32'hFFFFFFFF, 32'h0000FFFF, 4'd7,  32'hFFFF0000);
    add(6'd23, 32'h00F0,     32'h000F,     4'd8,  32'h00FF);
    add(6'd24, 32'h00F0,     32'h003C,     4'd9,  32'h0030);
    add(6'd25, 32'd1,        32'd31,       4'd10, 32'h80000000);
    add(6'd26, 32'hFFFFFFFF, 32'd28,       4'd11, 32'hF);

    #1;
    chk("reset_flag",   32'(cdb_flag),   32'd0);
    chk("reset_busy",   32'(alu_busy),   32'd0);
    chk("reset_rename", 32'(cdb_rename), 32'd0);
    chk("reset_value",  cdb_value,       32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fill FIFO, freeze with rdy=0, then async reset between edges
    issue(6'd28, 32'h11, 32'd0, 4'd1);
    issue(6'd28, 32'h22, 32'd0, 4'd2);
    @(negedge clk);
    chk("full_flag", 32'(cdb_flag), 32'd1);
    chk("full_busy", 32'(alu_busy), 32'd1);
    rdy = 1'b0; cdb_grant = 1'b1; flush = 1'b1;
    drive(6'd28, 32'h99, 32'd0, 4'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_flag",   32'(cdb_flag),   32'd1);
      chk("hold_rename", 32'(cdb_rename), 32'd1);
      chk("hold_value",  cdb_value,       32'h11);
      chk("hold_busy",   32'(alu_busy),   32'd1);
    end
    rdy = 1'b1; cdb_grant = 1'b0; flush = 1'b0; alu_mission = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_flag",   32'(cdb_flag),   32'd0);
    chk("arst_busy",   32'(alu_busy),   32'd0);
    chk("arst_rename", 32'(cdb_rename), 32'd0);
    chk("arst_value",  cdb_value,       32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_flag", 32'(cdb_flag), 32'd0);

    // Opcode table, one op at a time with grant held high
    cdb_grant = 1'b1;
    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      @(negedge clk);
      alu_mission = 1'b0;
      chk($sformatf("v%0d_flag_early", i), 32'(cdb_flag), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_flag", i),   32'(cdb_flag),   32'd1);
      chk($sformatf("v%0d_rename", i), 32'(cdb_rename), 32'(vecs[i].tag));
      chk($sformatf("v%0d_value", i),  cdb_value,       vecs[i].exp);
      @(negedge clk);
      chk($sformatf("v%0d_flag_late", i), 32'(cdb_flag), 32'd0);
    end

    // Issue-order result stream
    base = bq.size();
    issue(6'd35, 32'h80000000, 32'h21,       4'd1);
    issue(6'd32, 32'd1,        32'hFFFFFFFF, 4'd2);
    issue(6'd8,  32'hFFFFFFFF, 32'd0,        4'd3);
    wait_q(base, 3);
    chk_q("order0", base, 0, 4'd1, 32'hC0000000);
    chk_q("order1", base, 1, 4'd2, 32'd1);
    chk_q("order2", base, 2, 4'd3, 32'd0);

    // Backpressure: busy after second accept, rogue mission dropped, none lost
    @(negedge clk);
    cdb_grant = 1'b0;
    base = bq.size();
    issue(6'd28, 32'd1, 32'd0, 4'd1);
    issue(6'd28, 32'd2, 32'd0, 4'd2);
    chk("bp_busy", 32'(alu_busy), 32'd1);
    drive(6'd28, 32'h77, 32'd0, 4'd7);
    @(negedge clk);
    @(negedge clk);
    alu_mission = 1'b0;
    chk("bp_busy_full", 32'(alu_busy),   32'd1);
    chk("bp_head",      32'(cdb_rename), 32'd1);
    cdb_grant = 1'b1;
    issue(6'd28, 32'd3, 32'd0, 4'd3);
    wait_q(base, 3);
    repeat (5) @(negedge clk);
    chk("bp_count", 32'(bq.size() - base), 32'd3);
    chk_q("bp0", base, 0, 4'd1, 32'd1);
    chk_q("bp1", base, 1, 4'd2, 32'd2);
    chk_q("bp2", base, 2, 4'd3, 32'd3);

    // Flush with two buffered results and a concurrent mission
    cdb_grant = 1'b0;
    base = bq.size();
    issue(6'd28, 32'd4, 32'd0, 4'd4);
    issue(6'd28, 32'd5, 32'd0, 4'd5);
    @(negedge clk);
    chk("fl_pre_busy", 32'(alu_busy), 32'd1);
    flush = 1'b1;
    drive(6'd28, 32'd6, 32'd0, 4'd6);
    @(negedge clk);
    flush = 1'b0;
    alu_mission = 1'b0;
    chk("fl_flag", 32'(cdb_flag), 32'd0);
    chk("fl_busy", 32'(alu_busy), 32'd0);
    cdb_grant = 1'b1;
    repeat (5) @(negedge clk);
    chk("fl_flag_late", 32'(cdb_flag), 32'd0);
    chk("fl_no_bcast", 32'(bq.size() - base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule
